// File: rtl/mem_prefetch_unit.sv
// Instruction prefetch FIFO with one outstanding fetch, plus an independent single-access data port.
// A fetch starts one cycle after a free slot is seen, a data access one cycle after its request; both hold the bus until ack.
module mem_prefetch_unit #(
    parameter int                   DATA_SIZE  = 32,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [DATA_SIZE-1:0] RESET_ADDR = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [DATA_SIZE-1:0] flush_pc,
    input  logic                 inst_pop,
    output logic                 inst_valid,
    output logic [31:0]          inst,
    output logic [DATA_SIZE-1:0] inst_pc,
    input  logic                 rd_data_mem,
    input  logic                 wr_data_mem,
    output logic [DATA_SIZE-1:0] data_mem_dat,
    output logic                 data_done,
    output logic                 busy,
    output logic                 inst_mem_en,
    output logic [DATA_SIZE-1:0] inst_mem_addr,
    input  logic                 inst_mem_ack,
    input  logic [31:0]          inst_mem_rd_dat,
    output logic                 data_mem_en,
    output logic                 data_mem_we,
    input  logic                 data_mem_ack,
    input  logic [DATA_SIZE-1:0] data_mem_rd_dat
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_DISCARD} fetch_state_e;
    typedef enum logic {DATA_IDLE, DATA_ACCESS} data_state_e;

    fetch_state_e         fstate_q, fstate_d;
    data_state_e          dstate_q, dstate_d;
    logic [DATA_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_SIZE-1:0] fetch_addr_q, fetch_addr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 data_we_q, data_we_d;
    logic [DATA_SIZE-1:0] data_dat_q, data_dat_d;
    logic                 data_done_q, data_done_d;
    logic [DATA_SIZE-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]          fifo_inst_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic data_req;

    // A flush always wins: an acked word arriving with it is never written.
    assign push     = (fstate_q == FETCH_REQ) && inst_mem_ack && !flush;
    assign pop      = inst_pop && (count_q != '0) && !flush;
    assign data_req = rd_data_mem || wr_data_mem;

    // Fetch FSM
    always_ff @(posedge clock) begin
        if (reset) fstate_q <= FETCH_IDLE;
        else       fstate_q <= fstate_d;
    end

    // Only pops can happen while a fetch is in flight, so a free slot now is still free at ack.
    always_comb begin
        fstate_d = fstate_q;
        case (fstate_q)
            FETCH_IDLE:    if (!flush && ((count_q + CNT_W'(push)) < DEPTH_C)) fstate_d = FETCH_REQ;
            FETCH_REQ:     if (inst_mem_ack) fstate_d = FETCH_IDLE;
                           else if (flush)   fstate_d = FETCH_DISCARD;
            FETCH_DISCARD: if (inst_mem_ack) fstate_d = FETCH_IDLE;
            default:       fstate_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        inst_mem_en   = (fstate_q != FETCH_IDLE);
        inst_mem_addr = fetch_addr_q;
        inst_valid    = (count_q != '0);
        inst          = '0;
        inst_pc       = '0;
        if (inst_valid) begin
            inst    = fifo_inst_q[rd_ptr_q];
            inst_pc = fifo_pc_q[rd_ptr_q];
        end
    end

    // Data FSM
    always_ff @(posedge clock) begin
        if (reset) dstate_q <= DATA_IDLE;
        else       dstate_q <= dstate_d;
    end

    always_comb begin
        dstate_d = dstate_q;
        case (dstate_q)
            DATA_IDLE:   if (data_req) dstate_d = DATA_ACCESS;
            DATA_ACCESS: if (data_mem_ack) dstate_d = DATA_IDLE;
            default:     dstate_d = DATA_IDLE;
        endcase
    end

    always_comb begin
        data_mem_en  = (dstate_q == DATA_ACCESS);
        busy         = (dstate_q == DATA_ACCESS);
        data_mem_we  = (dstate_q == DATA_ACCESS) && data_we_q;
        data_mem_dat = data_dat_q;
        data_done    = data_done_q;
    end

    // Datapath next-state
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        fetch_addr_d = fetch_addr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        if (flush) begin
            fetch_pc_d = flush_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + DATA_SIZE'(4);
        end
        // The bus address is latched at launch so it stays put through a discard.
        if ((fstate_q == FETCH_IDLE) && (fstate_d == FETCH_REQ)) fetch_addr_d = fetch_pc_q;

        data_we_d   = data_we_q;
        data_dat_d  = data_dat_q;
        data_done_d = 1'b0;
        if ((dstate_q == DATA_IDLE) && data_req) data_we_d = wr_data_mem;
        if ((dstate_q == DATA_ACCESS) && data_mem_ack) begin
            data_done_d = 1'b1;
            if (!data_we_q) data_dat_d = data_mem_rd_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q   <= RESET_ADDR;
            fetch_addr_q <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_we_q    <= 1'b0;
            data_dat_q   <= '0;
            data_done_q  <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            fetch_addr_q <= fetch_addr_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_we_q    <= data_we_d;
            data_dat_q   <= data_dat_d;
            data_done_q  <= data_done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
            fifo_inst_q[wr_ptr_q] <= inst_mem_rd_dat;
        end
    end

endmodule

// File: tb/tb_mem_prefetch_unit.sv
// Directed bench for mem_prefetch_unit: data-port vector table plus fetch/flush/reset/wrap sequences.
module tb_mem_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        inst_pop = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        rd_data_mem = 1'b0;
    logic        wr_data_mem = 1'b0;
    logic [31:0] data_mem_dat;
    logic        data_done;
    logic        busy;
    logic        inst_mem_en;
    logic [31:0] inst_mem_addr;
    logic        inst_mem_ack;
    logic [31:0] inst_mem_rd_dat;
    logic        data_mem_en;
    logic        data_mem_we;
    logic        data_mem_ack;
    logic [31:0] data_mem_rd_dat;

    logic        inst_valid2, data_done2, busy2, inst_mem_en2, data_mem_en2, data_mem_we2;
    logic [31:0] inst2, inst_pc2, data_mem_dat2, inst_mem_addr2;
    logic        inst_mem_ack2;
    logic [31:0] inst_mem_rd_dat2;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          inst_lat = 1;
    int          data_lat = 1;
    logic [31:0] data_rd_value = '0;
    logic [31:0] fetch_log[$];
    logic [31:0] fetch_log2[$];

    always #5 clock = ~clock;

    mem_prefetch_unit #(.DATA_SIZE(32), .FIFO_DEPTH(4), .RESET_ADDR(32'h0)) dut (
        .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc), .inst_pop(inst_pop),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .rd_data_mem(rd_data_mem), .wr_data_mem(wr_data_mem), .data_mem_dat(data_mem_dat),
        .data_done(data_done), .busy(busy),
        .inst_mem_en(inst_mem_en), .inst_mem_addr(inst_mem_addr), .inst_mem_ack(inst_mem_ack),
        .inst_mem_rd_dat(inst_mem_rd_dat),
        .data_mem_en(data_mem_en), .data_mem_we(data_mem_we), .data_mem_ack(data_mem_ack),
        .data_mem_rd_dat(data_mem_rd_dat)
    );

    mem_prefetch_unit #(.DATA_SIZE(32), .FIFO_DEPTH(4), .RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .clock(clock), .reset(reset), .flush(zero_bit), .flush_pc(zero_word), .inst_pop(zero_bit),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
        .rd_data_mem(zero_bit), .wr_data_mem(zero_bit), .data_mem_dat(data_mem_dat2),
        .data_done(data_done2), .busy(busy2),
        .inst_mem_en(inst_mem_en2), .inst_mem_addr(inst_mem_addr2), .inst_mem_ack(inst_mem_ack2),
        .inst_mem_rd_dat(inst_mem_rd_dat2),
        .data_mem_en(data_mem_en2), .data_mem_we(data_mem_we2), .data_mem_ack(zero_bit),
        .data_mem_rd_dat(zero_word)
    );

    function automatic logic [31:0] iword(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_fetches(input int n, input int bound, input string name);
        int k = 0;
        while (fetch_log.size() < n && k < bound) begin
            @(negedge clock);
            k++;
        end
        check(name, 32'(fetch_log.size()), 32'(n));
    endtask

    // Instruction memory: ack after inst_lat cycles of inst_mem_en.
    initial begin
        int icnt = 0;
        inst_mem_ack = 1'b0;
        inst_mem_rd_dat = '0;
        forever begin
            @(negedge clock);
            if (inst_mem_en && !reset) begin
                icnt++;
                if (icnt >= inst_lat) begin
                    inst_mem_ack = 1'b1;
                    inst_mem_rd_dat = iword(inst_mem_addr);
                    fetch_log.push_back(inst_mem_addr);
                    icnt = 0;
                end else begin
                    inst_mem_ack = 1'b0;
                end
            end else begin
                inst_mem_ack = 1'b0;
                icnt = 0;
            end
        end
    end

    initial begin
        inst_mem_ack2 = 1'b0;
        inst_mem_rd_dat2 = '0;
        forever begin
            @(negedge clock);
            if (inst_mem_en2 && !reset && !inst_mem_ack2) begin
                inst_mem_ack2 = 1'b1;
                inst_mem_rd_dat2 = iword(inst_mem_addr2);
                fetch_log2.push_back(inst_mem_addr2);
            end else begin
                inst_mem_ack2 = 1'b0;
            end
        end
    end

    // Data memory: ack after data_lat cycles of data_mem_en.
    initial begin
        int dcnt = 0;
        data_mem_ack = 1'b0;
        data_mem_rd_dat = '0;
        forever begin
            @(negedge clock);
            if (data_mem_en && !reset) begin
                dcnt++;
                if (dcnt >= data_lat) begin
                    data_mem_ack = 1'b1;
                    data_mem_rd_dat = data_rd_value;
                    dcnt = 0;
                end else begin
                    data_mem_ack = 1'b0;
                end
            end else begin
                data_mem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        int          lat;
        logic [31:0] rdat;
        logic        exp_we;
        logic [31:0] exp_dat;
        int          exp_busy;
    } dvec_t;

    initial begin
        dvec_t dv[4];
        int busy_n, done_n, we_bad, early, k;
        logic found;

        dv[0] = '{1'b1, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3};
        dv[1] = '{1'b0, 1'b1, 1, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1};
        dv[2] = '{1'b1, 1'b1, 2, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF, 2};
        dv[3] = '{1'b1, 1'b0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_mem_en", 32'(inst_mem_en), 32'd0);
        check("rst_inst_mem_addr", inst_mem_addr, 32'd0);
        check("rst_data_mem_en", 32'(data_mem_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_done", 32'(data_done), 32'd0);
        check("rst_data_mem_dat", data_mem_dat, 32'd0);
        reset = 1'b0;

        // Fill: four fetches then the bus goes quiet
        wait_fetches(4, 40, "fill_count");
        repeat (8) @(negedge clock);
        check("fill_count_stable", 32'(fetch_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("fill_addr", fetch_log[i], 32'(i * 4));
        check("fill_en_idle", 32'(inst_mem_en), 32'd0);
        check("fill_valid", 32'(inst_valid), 32'd1);
        check("fill_head_pc", inst_pc, 32'h0);
        check("fill_head_inst", inst, iword(32'h0));

        check("wrap_first", fetch_log2[0], 32'hFFFF_FFFC);
        check("wrap_second", fetch_log2[1], 32'h0);
        check("wrap_head_pc", inst_pc2, 32'hFFFF_FFFC);
        check("wrap_head_inst", inst2, iword(32'hFFFF_FFFC));

        // One pop from full refills exactly one slot
        inst_pop = 1'b1;
        @(negedge clock);
        inst_pop = 1'b0;
        wait_fetches(5, 20, "refill_count");
        repeat (6) @(negedge clock);
        check("refill_addr", fetch_log[4], 32'h10);
        check("refill_count_stable", 32'(fetch_log.size()), 32'd5);
        check("refill_en_idle", 32'(inst_mem_en), 32'd0);
        check("refill_head_pc", inst_pc, 32'h4);

        // Data channel vector table
        for (int v = 0; v < 4; v++) begin
            data_lat = dv[v].lat;
            data_rd_value = dv[v].rdat;
            rd_data_mem = dv[v].rd;
            wr_data_mem = dv[v].wr;
            @(negedge clock);
            rd_data_mem = 1'b0;
            wr_data_mem = 1'b0;
            busy_n = 0; done_n = 0; we_bad = 0;
            repeat (dv[v].lat + 4) begin
                if (busy) busy_n++;
                if (data_mem_en && (data_mem_we !== dv[v].exp_we)) we_bad++;
                if (data_done) done_n++;
                @(negedge clock);
            end
            check("dvec_busy_cycles", 32'(busy_n), 32'(dv[v].exp_busy));
            check("dvec_done_pulses", 32'(done_n), 32'd1);
            check("dvec_we_errors", 32'(we_bad), 32'd0);
            check("dvec_data", data_mem_dat, dv[v].exp_dat);
        end

        // Read+write together is a write; a request while busy is dropped
        data_lat = 4;
        data_rd_value = 32'h1111_2222;
        rd_data_mem = 1'b1;
        wr_data_mem = 1'b1;
        @(negedge clock);
        rd_data_mem = 1'b0;
        wr_data_mem = 1'b0;
        done_n = 0; we_bad = 0;
        for (int i = 0; i < 12; i++) begin
            rd_data_mem = (i == 1);
            if (data_mem_en && !data_mem_we) we_bad++;
            if (data_done) done_n++;
            @(negedge clock);
        end
        rd_data_mem = 1'b0;
        check("busy_req_done_pulses", 32'(done_n), 32'd1);
        check("both_req_is_write", 32'(we_bad), 32'd0);
        check("write_keeps_data", data_mem_dat, 32'h0BAD_F00D);
        check("busy_req_idle_after", 32'(busy), 32'd0);

        // Reset while both channels wait on an ack
        inst_lat = 100;
        data_lat = 100;
        inst_pop = 1'b1;
        rd_data_mem = 1'b1;
        @(negedge clock);
        inst_pop = 1'b0;
        rd_data_mem = 1'b0;
        repeat (2) @(negedge clock);
        check("mid_inst_en", 32'(inst_mem_en), 32'd1);
        check("mid_data_en", 32'(data_mem_en), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_inst_en", 32'(inst_mem_en), 32'd0);
        check("mid_rst_data_en", 32'(data_mem_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_data_dat", data_mem_dat, 32'd0);
        inst_lat = 3;
        data_lat = 1;
        fetch_log.delete();
        @(negedge clock);
        reset = 1'b0;

        // Flush while the fetch at 0x8 waits on a slow ack
        found = 1'b0;
        k = 0;
        while (!found && k < 60) begin
            @(negedge clock);
            k++;
            if (inst_mem_en && inst_mem_addr == 32'h8) found = 1'b1;
        end
        check("flush_fetch8_seen", 32'(found), 32'd1);
        flush = 1'b1;
        flush_pc = 32'h200;
        @(negedge clock);
        flush = 1'b0;
        check("flush_valid_cleared", 32'(inst_valid), 32'd0);
        check("flush_en_held", 32'(inst_mem_en), 32'd1);
        check("flush_addr_held", inst_mem_addr, 32'h8);
        early = 0;
        k = 0;
        while (!(fetch_log.size() >= 4 && fetch_log[fetch_log.size() - 1] == 32'h200) && k < 40) begin
            if (inst_valid && inst_pc != 32'h200) early++;
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        check("flush_no_stale_valid", 32'(early), 32'd0);
        check("flush_log_count", 32'(fetch_log.size()), 32'd4);
        check("flush_acked_addr", fetch_log[2], 32'h8);
        check("flush_next_addr", fetch_log[3], 32'h200);
        check("flush_head_valid", 32'(inst_valid), 32'd1);
        check("flush_head_pc", inst_pc, 32'h200);
        check("flush_head_inst", inst, iword(32'h200));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
